// File: rtl/relay_stream_depacketizer.sv
// Leaf receiver for the relay chain: parses a one-word header, forwards payload
// addressed to my_addr through a 2-entry output buffer and discards the rest.
module relay_stream_depacketizer #(
  parameter int PAYLOAD_BITS = 32,
  parameter int ADDR_BITS    = 8,
  parameter int LEN_BITS     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    val_in,
  input  logic [PAYLOAD_BITS-1:0] din,
  output logic                    ready_upward,
  output logic                    val_out,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    last_out,
  input  logic                    ready_downward,
  input  logic [ADDR_BITS-1:0]    my_addr,
  output logic                    pkt_done,
  output logic [15:0]             drop_cnt
);

  // Handshake: a word moves when its valid and the receiver's ready are both
  // high at the rising edge; valid never waits on ready.
  typedef enum logic [1:0] {
    S_HDR     = 2'b00,
    S_PAYLOAD = 2'b01,
    S_DROP    = 2'b10
  } state_t;

  state_t                  state_q, state_d;
  logic [LEN_BITS-1:0]     remain_q, remain_d;
  logic [1:0]              occ_q, occ_d;
  logic [PAYLOAD_BITS-1:0] main_q, main_d, aux_q, aux_d;
  logic                    main_last_q, main_last_d, aux_last_q, aux_last_d;
  logic                    pkt_done_q, pkt_done_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;

  logic                    accept, pop, push, push_last, drop_inc, hdr_match;
  logic [ADDR_BITS-1:0]    hdr_addr;
  logic [LEN_BITS-1:0]     hdr_len;

  assign hdr_addr  = din[PAYLOAD_BITS-1 -: ADDR_BITS];
  assign hdr_len   = din[LEN_BITS-1:0];
  assign hdr_match = (hdr_addr == my_addr);
  assign accept    = val_in && ready_upward;
  assign pop       = val_out && ready_downward;

  // Ready is derived from registers only, so it never depends on ready_downward.
  always_comb begin
    ready_upward = 1'b0;
    case (state_q)
      S_HDR:     ready_upward = 1'b1;
      S_PAYLOAD: ready_upward = (occ_q != 2'd2);
      S_DROP:    ready_upward = 1'b1;
      default:   ready_upward = 1'b0;
    endcase
    if (reset) ready_upward = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    push       = 1'b0;
    push_last  = 1'b0;
    pkt_done_d = 1'b0;
    drop_inc   = 1'b0;
    case (state_q)
      S_HDR: begin
        if (accept) begin
          // A zero-length packet for another node still counts as dropped.
          if (hdr_len == '0) begin
            if (hdr_match) pkt_done_d = 1'b1;
            else           drop_inc   = 1'b1;
          end else if (hdr_match) begin
            state_d  = S_PAYLOAD;
            remain_d = hdr_len;
          end else begin
            state_d  = S_DROP;
            remain_d = hdr_len;
            drop_inc = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          push      = 1'b1;
          push_last = (remain_q == LEN_BITS'(1));
          remain_d  = remain_q - LEN_BITS'(1);
          if (remain_q == LEN_BITS'(1)) begin
            state_d    = S_HDR;
            pkt_done_d = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (accept) begin
          remain_d = remain_q - LEN_BITS'(1);
          if (remain_q == LEN_BITS'(1)) state_d = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  assign drop_cnt_d = (drop_inc && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;

  // Output buffer: main feeds dout; aux only fills when main is held by backpressure.
  always_comb begin
    occ_d       = occ_q;
    main_d      = main_q;
    main_last_d = main_last_q;
    aux_d       = aux_q;
    aux_last_d  = aux_last_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          main_d      = din;
          main_last_d = push_last;
        end else begin
          aux_d      = din;
          aux_last_d = push_last;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        main_d      = aux_q;
        main_last_d = aux_last_q;
        occ_d       = occ_q - 2'd1;
      end
      2'b11: begin
        main_d      = din;
        main_last_d = push_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_HDR;
      remain_q    <= '0;
      occ_q       <= 2'd0;
      main_q      <= '0;
      main_last_q <= 1'b0;
      aux_q       <= '0;
      aux_last_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
      drop_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      occ_q       <= occ_d;
      main_q      <= main_d;
      main_last_q <= main_last_d;
      aux_q       <= aux_d;
      aux_last_q  <= aux_last_d;
      pkt_done_q  <= pkt_done_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign val_out  = (occ_q != 2'd0);
  assign dout     = main_q;
  assign last_out = main_last_q;
  assign pkt_done = pkt_done_q;
  assign drop_cnt = drop_cnt_q;

endmodule
